serial_pattern_tx: RTL

Serial pattern transmitter that drives a 1-bit stream carrying a fixed or loaded bit pattern, MSB first, one bit per clock. It is the stimulus/transmit side of the FSM sequence-detector family: its `n` output feeds a detector's serial input directly, and the default pattern is 11011. Frames can repeat with a programmable count and a fixed idle gap between them. A start/ready handshake controls it, and a one-cycle `done` pulse marks completion.

---
 rtl/fsm_pkg.sv | 13 +
 rtl/frame_counter.sv | 28 ++
 rtl/serial_pattern_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the serial sequence transmitter/detector family.
// Holds the FSM state encoding and the reference 11011 pattern.
package fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [4:0] PAT_11011 = 5'b11011;

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// One-cycle update; decrement saturates at zero so the count never wraps.
module frame_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial MSB-first pattern transmitter with repeat count and inter-frame gap.
// First bit one cycle after start is accepted; start is ignored (not queued) while ready=0.
module serial_pattern_tx
  import fsm_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = PAT_11011,
  parameter int               GAP     = 2,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel_custom,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             ready,
  output logic             n,
  output logic             n_valid,
  output logic             done
);

  localparam int              BW      = $clog2(WIDTH);
  localparam logic [BW-1:0]   BIT_TOP = BW'(WIDTH - 1);
  localparam logic [3:0]      GAP_TOP = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sel_pat;
  logic             bit_zero, gap_zero, rep_zero;
  logic             accept, frame_end, more;
  logic             bit_load, bit_dec, gap_load, gap_dec, rep_dec;

  always_comb begin
    sel_pat   = sel_custom ? data_in : PATTERN;
    accept    = (state == S_IDLE) && start && ready;
    frame_end = (state == S_SHIFT) && bit_zero;
    more      = frame_end && !rep_zero;
    bit_load  = accept || (more && (GAP == 0)) || ((state == S_GAP) && gap_zero);
    bit_dec   = (state == S_SHIFT) && !bit_zero;
    gap_load  = more && (GAP > 0);
    gap_dec   = (state == S_GAP) && !gap_zero;
    rep_dec   = more;
  end

  frame_counter #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (BIT_TOP),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  frame_counter #(.W(4)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_TOP),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  frame_counter #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (repeat_n),
    .dec      (rep_dec),
    .zero     (rep_zero)
  );

  // sreg holds the bits still to be sent; n is registered one step ahead of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      pat_q   <= '0;
      ready   <= 1'b1;
      n       <= 1'b0;
      n_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            pat_q   <= sel_pat;
            sreg    <= sel_pat << 1;
            n       <= sel_pat[WIDTH-1];
            n_valid <= 1'b1;
            ready   <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bit_zero) begin
            n    <= sreg[WIDTH-1];
            sreg <= sreg << 1;
          end else if (rep_zero) begin
            n       <= 1'b0;
            n_valid <= 1'b0;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end else if (GAP > 0) begin
            n       <= 1'b0;
            n_valid <= 1'b0;
            sreg    <= pat_q;
            state   <= S_GAP;
          end else begin
            n    <= pat_q[WIDTH-1];
            sreg <= pat_q << 1;
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            n       <= sreg[WIDTH-1];
            n_valid <= 1'b1;
            sreg    <= sreg << 1;
            state   <= S_SHIFT;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready   <= 1'b1;
          n       <= 1'b0;
          n_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
